// File: rtl/run_length_scheduler.sv
// Round-robin scheduler that time-shares one longest-zero-run engine across NUM_CH lanes.
// Optional feature macro: RLS_RUN_COUNT_EN adds the zero-run counter and the o_run_cnt port.
module run_length_scheduler #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  parameter  int WIN_W  = 12,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_NOT_RESET,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_bit,
  input  logic [WIN_W-1:0]  i_win_len,
  output logic [NUM_CH-1:0] o_grant,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CH_W-1:0]   o_ch,
  output logic [CNT_W-1:0]  o_max_run
`ifdef RLS_RUN_COUNT_EN
  ,
  output logic [CNT_W-1:0]  o_run_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_REPORT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_ch;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_cur_run;
  logic [CNT_W-1:0] r_max_run;
  logic [CNT_W-1:0] w_cur_inc;
  logic             w_found;
  logic [CH_W-1:0]  w_pick;
  logic [CH_W:0]    w_sum;
  logic             w_s;

  // Round-robin search: first requester strictly after the last-served pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
      if (!w_found && i_req[w_sum[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_ARM;
      S_ARM:     w_state_nxt = (r_win_cnt == '0) ? S_REPORT : S_MEASURE;
      S_MEASURE: if (r_win_cnt == WIN_W'(1)) w_state_nxt = S_REPORT;
      S_REPORT:  if (i_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_NOT_RESET) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  assign w_s       = i_bit[r_ch];
  assign w_cur_inc = (r_cur_run == '1) ? r_cur_run : r_cur_run + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_NOT_RESET) begin
      r_ptr     <= CH_W'(NUM_CH - 1);
      r_ch      <= '0;
      r_win_cnt <= '0;
      r_cur_run <= '0;
      r_max_run <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_ch      <= w_pick;
          r_win_cnt <= i_win_len;
        end
        S_ARM: begin
          r_cur_run <= '0;
          r_max_run <= '0;
        end
        S_MEASURE: begin
          r_win_cnt <= r_win_cnt - 1'b1;
          if (!w_s) begin
            r_cur_run <= w_cur_inc;
            if (w_cur_inc > r_max_run) r_max_run <= w_cur_inc;
          end else begin
            r_cur_run <= '0;
          end
        end
        S_REPORT: if (i_ready) r_ptr <= r_ch;
        default: ;
      endcase
    end
  end

`ifdef RLS_RUN_COUNT_EN
  logic [CNT_W-1:0] r_run_cnt;

  // A new run starts whenever a zero arrives while the current run is empty.
  always_ff @(posedge i_clk) begin
    if (!i_NOT_RESET) begin
      r_run_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_run_cnt <= '0;
    end else if (r_state == S_MEASURE && !w_s && r_cur_run == '0 && r_run_cnt != '1) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  assign o_run_cnt = r_run_cnt;
`endif

  always_comb begin
    o_grant = '0;
    if (r_state != S_IDLE) o_grant[r_ch] = 1'b1;
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_valid   = (r_state == S_REPORT);
  assign o_ch      = r_ch;
  assign o_max_run = r_max_run;

endmodule

// File: tb/tb_run_length_scheduler.sv
// Randomized scoreboard bench for run_length_scheduler with a window-level reference model.
module tb_run_length_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 6;
  localparam int SAT    = (1 << CNT_W) - 1;

  typedef struct {
    int ch;
    int max_run;
    int run_cnt;
  } exp_t;

  logic              i_clk;
  logic              i_NOT_RESET;
  logic [NUM_CH-1:0] i_req;
  logic [NUM_CH-1:0] i_bit;
  logic [WIN_W-1:0]  i_win_len;
  logic              i_ready;
  logic [NUM_CH-1:0] o_grant;
  logic              o_busy;
  logic              o_valid;
  logic [1:0]        o_ch;
  logic [CNT_W-1:0]  o_max_run;
`ifdef RLS_RUN_COUNT_EN
  logic [CNT_W-1:0]  o_run_cnt;
`endif

  int   n_vec = 0;
  int   n_bad = 0;
  int   ptr;
  exp_t sb[$];

  run_length_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .i_clk       (i_clk),
    .i_NOT_RESET (i_NOT_RESET),
    .i_req       (i_req),
    .i_bit       (i_bit),
    .i_win_len   (i_win_len),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_ch        (o_ch),
    .o_max_run   (o_max_run)
`ifdef RLS_RUN_COUNT_EN
    ,
    .o_run_cnt   (o_run_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] req, input int last);
    for (int k = 1; k <= NUM_CH; k++)
      if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  // Longest zero run and number of zero runs over the whole window, clamped afterwards.
  function automatic exp_t model(input int ch, input int bits[$]);
    exp_t e;
    int   run = 0;
    int   longest = 0;
    int   runs = 0;
    foreach (bits[j]) begin
      if (bits[j] == 0) begin
        if (run == 0) runs++;
        run++;
        if (run > longest) longest = run;
      end else begin
        run = 0;
      end
    end
    e.ch      = ch;
    e.max_run = (longest > SAT) ? SAT : longest;
    e.run_cnt = (runs > SAT) ? SAT : runs;
    return e;
  endfunction

  // Monitor: compares the head of the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #3;
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("valid_without_txn", int'(o_valid), 0);
        end else begin
          e = sb[0];
          check("res_ch", int'(o_ch), e.ch);
          check("res_max_run", int'(o_max_run), e.max_run);
`ifdef RLS_RUN_COUNT_EN
          check("res_run_cnt", int'(o_run_cnt), e.run_cnt);
`endif
          if (i_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_txn(input logic [NUM_CH-1:0] req, input int len, input int rdy_dly,
                        input bit force_bits, input logic [31:0] pat);
    int                ch;
    int                bits[$];
    logic [NUM_CH-1:0] gexp;
    ch        = pick(req, ptr);
    gexp      = NUM_CH'(1) << ch;
    i_req     = req;
    i_win_len = WIN_W'(len);
    i_ready   = (rdy_dly == 0);
    i_bit     = NUM_CH'($urandom);
    @(posedge i_clk);
    @(negedge i_clk);
    check("grant", int'(o_grant), int'(gexp));
    check("grant_busy", int'(o_busy), 1);
    check("grant_ch", int'(o_ch), ch);
    check("early_valid", int'(o_valid), 0);
    i_req = NUM_CH'($urandom);
    i_bit = NUM_CH'($urandom);
    @(posedge i_clk);
    for (int j = 0; j < len; j++) begin
      @(negedge i_clk);
      check("early_valid", int'(o_valid), 0);
      i_bit = NUM_CH'($urandom);
      if (force_bits) i_bit[ch] = pat[j];
      bits.push_back(int'(i_bit[ch]));
      @(posedge i_clk);
    end
    sb.push_back(model(ch, bits));
    @(negedge i_clk);
    check("valid_latency", int'(o_valid), 1);
    for (int d = 0; d < rdy_dly; d++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("hold_valid", int'(o_valid), 1);
      check("hold_grant", int'(o_grant), int'(gexp));
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    ptr = ch;
    @(negedge i_clk);
    check("idle_busy", int'(o_busy), 0);
    check("idle_valid", int'(o_valid), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, int'(o_grant), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_ch"}, int'(o_ch), 0);
    check({tag, "_max_run"}, int'(o_max_run), 0);
`ifdef RLS_RUN_COUNT_EN
    check({tag, "_run_cnt"}, int'(o_run_cnt), 0);
`endif
  endtask

  // Reset lands after four window samples of a ten-sample measurement.
  task automatic do_abort();
    int ch;
    ch        = pick(4'b1111, ptr);
    i_req     = 4'b1111;
    i_win_len = WIN_W'(10);
    i_ready   = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("abort_grant_ch", int'(o_ch), ch);
    i_req = '0;
    @(posedge i_clk);
    repeat (4) begin
      @(negedge i_clk);
      i_bit = NUM_CH'($urandom);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_NOT_RESET = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("abort");
    i_NOT_RESET = 1'b1;
    ptr = NUM_CH - 1;
    repeat (3) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("abort_valid_stays_low", int'(o_valid), 0);
    end
  endtask

  initial begin
    i_NOT_RESET = 1'b0;
    i_req       = '0;
    i_bit       = '0;
    i_win_len   = '0;
    i_ready     = 1'b0;
    ptr         = NUM_CH - 1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_NOT_RESET = 1'b1;

    do_txn(4'b0101, 5, 0, 1'b1, 32'h0000_0004);
    do_txn(4'b0101, 5, 0, 1'b0, 32'h0);
    do_txn(4'b0010, 20, 0, 1'b1, 32'h0);
    repeat (5) do_txn(4'b1111, 1, 0, 1'b0, 32'h0);
    do_abort();
    do_txn(4'b1111, 3, 0, 1'b0, 32'h0);
    do_txn(4'b0100, 0, 0, 1'b0, 32'h0);
    do_txn(4'b1000, 4, 3, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++)
      do_txn(NUM_CH'($urandom_range(1, 15)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 2)), 1'b0, 32'h0);

    repeat (2) @(posedge i_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/run_length_scheduler.md
# run_length_scheduler

Time-shares one zero-run-length measurement engine between `NUM_CH` serial bit-stream channels. A channel raises a request and is granted by round-robin. The engine then measures the longest run of consecutive `0` samples on that channel over a programmable window of `i_win_len` cycles. The result is returned through a valid/ready handshake. The block sits in front of the counter datapath and replaces per-channel run-length counters in multi-lane link monitors.

## Interface

Parameters:

- `NUM_CH`, default 4: number of requesting channels, 2..16.
- `CNT_W`, default 8: width of the run-length result. Results saturate at 2^CNT_W-1.
- `WIN_W`, default 12: width of the window-length input.

Ports:

- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_NOT_RESET`  in  1  reset; synchronous, active-low.
- `i_req`  in  `NUM_CH`  level request per channel.
- `i_bit`  in  `NUM_CH`  serial data per channel; only the granted lane is sampled.
- `i_win_len`  in  `WIN_W`  window length in cycles; latched at grant.
- `o_grant`  out  `NUM_CH`  one-hot; held from ARM through REPORT.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_valid`  out  1  result valid; high in REPORT.
- `i_ready`  in  1  result consumer ready.
- `o_ch`  out  `$clog2(NUM_CH)`  index of the channel owning the result or grant.
- `o_max_run`  out  `CNT_W`  longest zero run in the window.
- `o_run_cnt`  out  `CNT_W`  number of zero runs. Present only with `RLS_RUN_COUNT_EN`.

## Operation

- **States:** IDLE, ARM, MEASURE, REPORT.
- **IDLE:**
  - If any `i_req` is set, select the first requesting channel strictly after the last-served pointer, wrapping.
  - Latch the channel index and `i_win_len`, then go to ARM.
  - With no request, stay in IDLE.
- **ARM (1 cycle):**
  - Clear `cur_run`, `max_run` and `run_cnt`. Load `win_cnt` with the latched length.
  - If the latched length is 0, go to REPORT (result 0). Otherwise go to MEASURE.
- **MEASURE (one cycle per window sample), sampling `s = i_bit[ch]`:**
  - If `s==0`: `cur_run` = `cur_run`+1 (saturating). `max_run` = max(`max_run`, `cur_run`+1) (saturating). If `cur_run==0`, also `run_cnt`+1 (saturating).
  - If `s==1`: `cur_run` = 0.
  - `win_cnt` decrements; at `win_cnt==1`, go to REPORT.
- **REPORT:**
  - `o_valid`=1; `o_max_run`, `o_run_cnt` and `o_ch` are stable.
  - On `o_valid && i_ready`: update the pointer to the served channel, drop the grant, go to IDLE.
- **Request handling:**
  - Deasserting `i_req` after grant does not abort the transaction.
  - Other channels' `i_req`/`i_bit` are ignored while busy.
- **Saturation:** `cur_run`, `max_run` and `run_cnt` stick at 2^CNT_W-1; no wrap.
- **Reset (`i_NOT_RESET==0` at an edge), from any state including mid-MEASURE or REPORT:**
  - State goes to IDLE.
  - `o_grant`=0, `o_busy`=0, `o_valid`=0, `o_ch`=0, `o_max_run`=0, `o_run_cnt`=0.
  - Pointer = `NUM_CH`-1, so channel 0 has first priority.
  - An unfinished result is discarded.

## Timing

- Request seen in IDLE at edge t:
  - `o_grant`/`o_busy` are high after t.
  - ARM occupies cycle t..t+1.
  - With window L≥1, samples are taken at edges t+2..t+1+L.
  - `o_valid` rises after edge t+1+L.
- Grant-to-valid latency is L+1 cycles; L=0 gives 1 cycle.
- `i_ready` already high: REPORT lasts 1 cycle.
- After the handshake edge, the block spends at least one cycle in IDLE before the next grant. Back-to-back service spacing is L+3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- **`RLS_RUN_COUNT_EN` defined:** the `run_cnt` register and the `o_run_cnt` port exist. `run_cnt` counts the 1→0 transitions in the window, plus 1 if the first sample is 0.
- **`RLS_RUN_COUNT_EN` undefined:** the port and register are removed. All other behaviour is identical.

## Test plan

- Reset, then `i_req`=4'b0101, L=5, `i_ready`=1, ch0 bits 0,0,1,0,0 → grant 4'b0001; `o_max_run`=2, `o_run_cnt`=2; valid at cycle 7; next grant 4'b0100.
- Saturation: `CNT_W`=4, L=20, all zeros → `o_max_run`=15, `o_run_cnt`=1.
- All four channels requesting continuously, L=1 → grant order 0,1,2,3,0; spacing 4 cycles.
- L=0 on ch2 → `o_valid` one cycle after ARM; `o_max_run`=0, `o_ch`=2.
- `i_ready` held low 3 cycles in REPORT → `o_valid` and data stable; no new grant until handshake.
- Reset asserted mid-MEASURE (L=10, cycle 4) → next edge: `o_busy`=0, `o_grant`=0, `o_valid` stays 0; the next request is served from ch0 priority.
